// File: rtl/bit_serial_sub_pkg.sv
// bit_serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package bit_serial_sub_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit full subtractor cell, x - y - bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/bit_serial_subtractor.sv
// bit_serial_subtractor: LSB-first serial a - b with valid/ready handshakes
// Optional signed overflow output enabled by defining SERIAL_SUB_OVF_EN.
module bit_serial_subtractor
  import bit_serial_sub_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] a_sh, b_sh, diff_sh;
  logic [CW-1:0] cnt;
  logic borrow, d, bo, last;
  full_subtractor u_fs (.a(a_sh[0]), .b(b_sh[0]), .bin(borrow), .diff(d), .bout(bo));
  assign last = cnt == CW'(DATA_WIDTH - 1);
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (in_valid ? BUSY : IDLE)
             : state == BUSY ? (last ? DONE : BUSY)
             : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (state == BUSY) begin
        diff_sh <= {d, diff_sh[DATA_WIDTH-1:1]};
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        borrow  <= bo;
        cnt     <= last ? cnt : cnt + 1'b1;
      end
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // overflow when the borrow into the sign bit differs from the borrow out of it
  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else if (state == BUSY && last) ovf_q <= borrow ^ bo;
  end
  assign ovf = ovf_q;
`endif
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign diff      = diff_sh;
  assign bout      = borrow;
endmodule
